// File: rtl/spi_cmd_slave_ctrl.sv
// spi_cmd_slave_ctrl
//   System-bus master for the iCE40UP SB_SPI hard IP running as an SPI slave.
//   Programs SB_SPI once after reset, waits for the host init byte, then
//   decodes 8-byte command frames and drives the board LEDs. Replies go out
//   on MISO as a one-byte-lagged stream: TX_FIRST ahead of byte 0, then the
//   reply computed from byte k ahead of byte k+1 (k = 0..4).
// Ports
//   clk      system clock (24 MHz), all logic on posedge
//   reset    synchronous, active-high
//   sb_stb   SBSTBI strobe, held until sb_ack
//   sb_rw    SBRWI, 1 = write, 0 = read
//   sb_adr   SBADRI[7:0]
//   sb_dati  SBDATI[7:0]
//   sb_dato  SBDATO[7:0]
//   sb_ack   SBACKO
//   led      LED state {B,G,R}, active-high
module spi_cmd_slave_ctrl #(
  parameter logic [7:0]  OP_WR_INVERTED = 8'h02,
  parameter logic [7:0]  OP_WR_LEDS     = 8'h04,
  parameter logic [7:0]  OP_WR_VEC      = 8'h06,
  parameter logic [7:0]  OP_RD_VEC      = 8'h07,
  parameter logic [7:0]  INIT_BYTE      = 8'h11,
  parameter logic [7:0]  TX_FIRST       = 8'h40,
  parameter int unsigned FRAME_LEN      = 8,
  parameter int unsigned TX_MAX         = 6,
  parameter logic [7:0]  ADR_CR0        = 8'h08,
  parameter logic [7:0]  ADR_CR1        = 8'h09,
  parameter logic [7:0]  ADR_CR2        = 8'h0A,
  parameter logic [7:0]  ADR_BR         = 8'h0B,
  parameter logic [7:0]  ADR_CSR        = 8'h0F,
  parameter logic [7:0]  ADR_SR         = 8'h0C,
  parameter logic [7:0]  ADR_TXDR       = 8'h0D,
  parameter logic [7:0]  ADR_RXDR       = 8'h0E
) (
  input  logic       clk,
  input  logic       reset,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dati,
  input  logic [7:0] sb_dato,
  input  logic       sb_ack,
  output logic [2:0] led
);

  localparam int unsigned RD_W      = $clog2(FRAME_LEN);
  localparam int unsigned TX_W      = $clog2(TX_MAX + 1);
  localparam int unsigned VEC_BYTES = 4;

  typedef enum logic [3:0] {
    CFG_CR0, CFG_CR1, CFG_CR2, CFG_BR, CFG_CSR,
    WAIT_RX, WAIT_TRDY, TRANSMIT, READ_INIT, READ_OP
  } state_t;

  state_t          state;
  logic            initialized;
  logic [RD_W-1:0] rd_cnt;
  logic [TX_W-1:0] tx_cnt;
  logic [3:0]      vec_idx;
  logic [7:0]      vec [16];
  logic [7:0]      opcode;
  logic [2:0]      led_arg;
  logic [7:0]      reply;

  logic            acked;
  logic            vec_slot;
  logic            vec_wr;
  logic            req_rw;
  logic [7:0]      req_adr;
  logic [7:0]      req_dati;

  assign acked    = sb_stb & sb_ack;
  // Payload bytes 1..4 of a frame are the vector bytes.
  assign vec_slot = (rd_cnt != '0) && (rd_cnt <= RD_W'(VEC_BYTES));
  assign vec_wr   = !reset && acked && (state == READ_OP) && vec_slot &&
                    (opcode == OP_WR_VEC);

  // Bus request presented by each state while its access is outstanding.
  always_comb begin
    req_rw   = 1'b0;
    req_adr  = ADR_SR;
    req_dati = '0;
    case (state)
      CFG_CR0:   begin req_rw = 1'b1; req_adr = ADR_CR0; req_dati = 8'h00; end
      CFG_CR1:   begin req_rw = 1'b1; req_adr = ADR_CR1; req_dati = 8'h80; end
      CFG_CR2:   begin req_rw = 1'b1; req_adr = ADR_CR2; req_dati = 8'h01; end
      CFG_BR:    begin req_rw = 1'b1; req_adr = ADR_BR;  req_dati = 8'h00; end
      CFG_CSR:   begin req_rw = 1'b1; req_adr = ADR_CSR; req_dati = 8'h00; end
      WAIT_RX,
      WAIT_TRDY: req_adr = ADR_SR;
      TRANSMIT:  begin
        req_rw   = 1'b1;
        req_adr  = ADR_TXDR;
        req_dati = (tx_cnt == '0) ? TX_FIRST : reply;
      end
      READ_INIT,
      READ_OP:   req_adr = ADR_RXDR;
      default:   ;
    endcase
  end

  // Vector RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (vec_wr) vec[vec_idx] <= sb_dato;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CFG_CR0;
      sb_stb      <= 1'b0;
      sb_rw       <= 1'b0;
      sb_adr      <= '0;
      sb_dati     <= '0;
      led         <= '0;
      initialized <= 1'b0;
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      vec_idx     <= '0;
    end else begin
      sb_stb <= 1'b0;
      if (!acked) begin
        // Dropping stb on the ack cycle guarantees one idle cycle per access.
        sb_stb  <= 1'b1;
        sb_rw   <= req_rw;
        sb_adr  <= req_adr;
        sb_dati <= req_dati;
      end else begin
        case (state)
          CFG_CR0: state <= CFG_CR1;
          CFG_CR1: state <= CFG_CR2;
          CFG_CR2: state <= CFG_BR;
          CFG_BR:  state <= CFG_CSR;
          CFG_CSR: begin
            state  <= WAIT_RX;
            rd_cnt <= '0;
          end
          WAIT_RX: begin
            if (sb_dato[3]) begin
              if (!initialized)                 state <= READ_INIT;
              else if (tx_cnt < TX_W'(TX_MAX))  state <= WAIT_TRDY;
              else                              state <= READ_OP;
            end
          end
          WAIT_TRDY: begin
            if (sb_dato[4]) state <= TRANSMIT;
          end
          TRANSMIT: begin
            tx_cnt <= tx_cnt + 1'b1;
            state  <= READ_OP;
          end
          READ_INIT: begin
            state <= WAIT_RX;
            if (sb_dato == INIT_BYTE) begin
              initialized <= 1'b1;
              rd_cnt      <= '0;
              tx_cnt      <= '0;
            end
          end
          READ_OP: begin
            state  <= WAIT_RX;
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == '0) begin
              opcode <= sb_dato;
              reply  <= sb_dato;
            end else begin
              // Only the LED field of byte 1 matters, and only at frame end.
              if (rd_cnt == RD_W'(1)) led_arg <= sb_dato[2:0];
              case (opcode)
                OP_WR_INVERTED: reply <= ~sb_dato;
                OP_WR_LEDS:     reply <= sb_dato;
                OP_WR_VEC: begin
                  if (vec_slot) vec_idx <= vec_idx + 4'd1;
                end
                OP_RD_VEC: begin
                  if (vec_slot) begin
                    reply   <= vec[vec_idx];
                    vec_idx <= vec_idx + 4'd1;
                  end
                end
                default: ;
              endcase
            end
            if (rd_cnt == RD_W'(FRAME_LEN - 1)) begin
              rd_cnt <= '0;
              tx_cnt <= '0;
              if (opcode == OP_WR_LEDS) led <= led_arg;
            end
          end
          default: state <= CFG_CR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave_ctrl.sv
// Testbench for spi_cmd_slave_ctrl: SB_SPI bus model (ack one cycle after
// stb, scripted SR/RXDR), frame-level reference model feeding expectation
// queues, and a monitor that checks every completed bus access.
module tb_spi_cmd_slave_ctrl;

  localparam logic [7:0] ADR_SR   = 8'h0C;
  localparam logic [7:0] ADR_TXDR = 8'h0D;
  localparam logic [7:0] ADR_RXDR = 8'h0E;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dati;
  logic [7:0] sb_dato = 8'h00;
  logic       sb_ack = 1'b0;
  logic [2:0] led;

  spi_cmd_slave_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .sb_stb  (sb_stb),
    .sb_rw   (sb_rw),
    .sb_adr  (sb_adr),
    .sb_dati (sb_dati),
    .sb_dato (sb_dato),
    .sb_ack  (sb_ack),
    .led     (led)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [2:0] led; } rx_t;
  typedef struct { logic [7:0] adr;  logic [7:0] dat; } cfg_t;

  rx_t        rx_q[$];
  logic [7:0] tx_q[$];
  logic [2:0] led_fifo[$];
  cfg_t       cfg_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic       led_pend  = 1'b0;
  logic [2:0] led_exp   = 3'b000;
  logic       was_acked = 1'b0;
  cfg_t       mon_c;

  // Reference model state
  logic       m_init;
  logic [7:0] m_vec [16];
  logic [3:0] m_idx;
  logic [2:0] m_led;
  logic [7:0] fr [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_cfg();
    cfg_t c;
    c.adr = 8'h08; c.dat = 8'h00; cfg_q.push_back(c);
    c.adr = 8'h09; c.dat = 8'h80; cfg_q.push_back(c);
    c.adr = 8'h0A; c.dat = 8'h01; cfg_q.push_back(c);
    c.adr = 8'h0B; c.dat = 8'h00; cfg_q.push_back(c);
    c.adr = 8'h0F; c.dat = 8'h00; cfg_q.push_back(c);
  endtask

  task automatic push_rx(input logic [7:0] b, input logic [2:0] l);
    rx_t e;
    e.data = b;
    e.led  = l;
    rx_q.push_back(e);
  endtask

  // Bytes sent before the controller is initialized: never answered.
  task automatic send_raw(input logic [7:0] b);
    if (!m_init && b == 8'h11) m_init = 1'b1;
    push_rx(b, m_led);
  endtask

  // One full frame: the six replies it produces and the LED state after
  // each of its bytes is consumed.
  task automatic send_frame(input logic [7:0] f [8]);
    logic [7:0] r [5];
    logic [2:0] nl;
    r[0] = f[0];
    for (int unsigned k = 1; k < 5; k++) begin
      case (f[0])
        8'h02: r[k] = ~f[k];
        8'h04: r[k] = f[k];
        8'h06: begin m_vec[m_idx] = f[k]; m_idx = m_idx + 4'd1; r[k] = f[0]; end
        8'h07: begin r[k] = m_vec[m_idx]; m_idx = m_idx + 4'd1; end
        default: r[k] = f[0];
      endcase
    end
    nl = (f[0] == 8'h04) ? f[1][2:0] : m_led;
    tx_q.push_back(8'h40);
    for (int unsigned k = 0; k < 5; k++) tx_q.push_back(r[k]);
    for (int unsigned i = 0; i < 8; i++) push_rx(f[i], (i == 7) ? nl : m_led);
    m_led = nl;
  endtask

  task automatic set_fr(input logic [63:0] v);
    for (int unsigned i = 0; i < 8; i++) fr[i] = v[8*(7-i) +: 8];
  endtask

  task automatic rand_frame();
    logic [7:0] f [8];
    for (int unsigned i = 0; i < 8; i++) f[i] = 8'($urandom);
    case ($urandom_range(0, 4))
      0: f[0] = 8'h02;
      1: f[0] = 8'h04;
      2: f[0] = 8'h06;
      3: f[0] = 8'h07;
      default: ;
    endcase
    send_frame(f);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0 || led_fifo.size() != 0 ||
            cfg_q.size() != 0 || led_pend) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("drain_timeout", t < 20000, 1);
  endtask

  // SB_SPI bus model
  always @(posedge clk) begin
    rx_t e;
    logic rrdy, trdy;
    sb_ack <= 1'b0;
    if (sb_stb && !sb_ack) begin
      sb_ack <= 1'b1;
      if (!sb_rw && sb_adr == ADR_SR) begin
        rrdy = (rx_q.size() != 0) && ($urandom_range(0, 3) != 0);
        trdy = ($urandom_range(0, 3) != 0);
        sb_dato <= {3'b000, trdy, rrdy, 3'b000};
      end else if (!sb_rw && sb_adr == ADR_RXDR) begin
        check("rx_avail", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          e = rx_q.pop_front();
          sb_dato <= e.data;
          led_fifo.push_back(e.led);
        end else begin
          sb_dato <= 8'h00;
        end
      end else begin
        sb_dato <= 8'h00;
      end
    end
  end

  // Monitor: checks every completed access and the LED state after reads.
  always @(negedge clk) begin
    if (reset) begin
      was_acked = 1'b0;
      led_pend  = 1'b0;
    end else begin
      if (led_pend) begin
        check("led", led, led_exp);
        led_pend = 1'b0;
      end
      if (was_acked) check("stb_idle", sb_stb, 0);
      was_acked = sb_stb && sb_ack;
      if (sb_stb && sb_ack) begin
        if (sb_rw && sb_adr == ADR_TXDR) begin
          check("txdr_expected", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) check("txdr", sb_dati, tx_q.pop_front());
        end else if (sb_rw) begin
          check("cfg_expected", cfg_q.size() != 0, 1);
          if (cfg_q.size() != 0) begin
            mon_c = cfg_q.pop_front();
            check("cfg_adr", sb_adr, mon_c.adr);
            check("cfg_dat", sb_dati, mon_c.dat);
          end
        end else begin
          check("rd_adr", (sb_adr == ADR_SR || sb_adr == ADR_RXDR) && cfg_q.size() == 0, 1);
          if (sb_adr == ADR_RXDR && led_fifo.size() != 0) begin
            led_exp  = led_fifo.pop_front();
            led_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic found;
    m_init = 1'b0;
    m_idx  = 4'd0;
    m_led  = 3'b000;
    push_cfg();

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stb",  sb_stb,  0);
    check("rst_rw",   sb_rw,   0);
    check("rst_adr",  sb_adr,  0);
    check("rst_dati", sb_dati, 0);
    check("rst_led",  led,     0);
    reset = 1'b0;

    // Pre-init traffic is consumed silently; 0x11 initializes.
    send_raw(8'h55);
    drain();
    send_raw(8'h11);
    drain();

    set_fr(64'h04_05_00_00_00_00_00_00); send_frame(fr);
    set_fr(64'h02_0F_F0_AA_55_00_00_00); send_frame(fr);
    set_fr(64'h06_00_01_02_03_00_00_00); send_frame(fr);
    set_fr(64'h06_10_11_12_13_00_00_00); send_frame(fr);
    set_fr(64'h06_20_21_22_23_00_00_00); send_frame(fr);
    set_fr(64'h06_30_31_32_33_00_00_00); send_frame(fr);
    set_fr(64'h07_00_00_00_00_00_00_00); send_frame(fr);
    drain();

    for (int unsigned n = 0; n < 20; n++) rand_frame();
    drain();

    set_fr(64'h04_06_00_00_00_00_00_00); send_frame(fr);
    drain();

    // Reset in the middle of a frame's first RXDR access.
    set_fr(64'h33_01_02_03_04_05_06_07); send_frame(fr);
    found = 1'b0;
    for (int unsigned t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (sb_stb && !sb_ack && !sb_rw && sb_adr == ADR_RXDR) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_seen", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_stb", sb_stb, 0);
    check("mid_rst_led", led, 0);
    repeat (2) @(negedge clk);
    rx_q.delete();
    tx_q.delete();
    led_fifo.delete();
    cfg_q.delete();
    push_cfg();
    m_init = 1'b0;
    m_idx  = 4'd0;
    m_led  = 3'b000;
    reset = 1'b0;

    // Config repeats; init required again; vector RAM contents survive.
    send_raw(8'h5A);
    send_raw(8'h22);
    send_raw(8'h11);
    set_fr(64'h07_00_00_00_00_00_00_00); send_frame(fr);
    for (int unsigned n = 0; n < 6; n++) rand_frame();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
